// File: rtl/fp_div_pkg.sv
// ============================================================================
//  Module   : fp_div_pkg
//  Purpose  : Shared types and constants for the single-precision divider
//             (operand preparation front-end and divider core).
//  Contents : state_t     - operand-prep FSM states
//             fp_class_t  - binary32 operand classes
//             FP_BIAS, FP_QNAN, FP_EXP_W
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_div_pkg;

  localparam int          FP_BIAS  = 127;
  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
  localparam int          FP_EXP_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLASSIFY = 2'd1,
    ST_NORM     = 2'd2,
    ST_ISSUE    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_SUB    = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } fp_class_t;

endpackage

`default_nettype wire

// File: rtl/fp_div_operand_prep_if.sv
// ============================================================================
//  Module   : fp_div_operand_prep_if
//  Purpose  : Operand-in / issue-out bundle of the divider front-end.
//  Modports : slave  - front-end side (accepts operands, drives issue word)
//             master - producer/consumer side (drives operands, out_ready)
//  Signals  : in_valid/in_ready/n/x                 operand handshake
//             out_valid/out_ready/sign/exp_diff/
//             mant_n/mant_x/special/special_res     issue handshake
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_div_operand_prep_if;
  import fp_div_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                n;
  logic [31:0]                x;
  logic                       out_valid;
  logic                       out_ready;
  logic                       sign;
  logic signed [FP_EXP_W-1:0] exp_diff;
  logic [23:0]                mant_n;
  logic [23:0]                mant_x;
  logic                       special;
  logic [31:0]                special_res;

  modport slave (
    input  in_valid, n, x, out_ready,
    output in_ready, out_valid, sign, exp_diff, mant_n, mant_x, special, special_res
  );

  modport master (
    output in_valid, n, x, out_ready,
    input  in_ready, out_valid, sign, exp_diff, mant_n, mant_x, special, special_res
  );

endinterface

`default_nettype wire

// File: rtl/fp_classify.sv
// ============================================================================
//  Module   : fp_classify
//  Purpose  : Combinational binary32 classifier. Produces the operand class,
//             the raw (not yet normalised) 24-bit mantissa and the effective
//             exponent. Sign is handled by the caller.
//  Ports    : op      in  31  binary32 word without sign bit
//             cls     out     ZERO / SUB / NORMAL / INF / NAN
//             mant    out 24  {hidden, frac}; 0 for ZERO/INF/NAN
//             eff_exp out 10  exponent field, 1 for SUB, 0 otherwise
//  Config   : FP_DIV_PREP_DENORM_EN - when undefined, subnormals classify
//             as ZERO (flush to zero)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_classify
  import fp_div_pkg::*;
(
  input  logic [30:0]                op,
  output fp_class_t                  cls,
  output logic [23:0]                mant,
  output logic signed [FP_EXP_W-1:0] eff_exp
);

  logic [7:0]  w_exp;
  logic [22:0] w_frac;

  assign w_exp  = op[30:23];
  assign w_frac = op[22:0];

  always_comb begin
    cls     = CLS_NORMAL;
    mant    = {1'b1, w_frac};
    eff_exp = {{(FP_EXP_W-8){1'b0}}, w_exp};
    if (w_exp == 8'hFF) begin
      cls     = (w_frac == 23'd0) ? CLS_INF : CLS_NAN;
      mant    = '0;
      eff_exp = '0;
    end else if (w_exp == 8'h00) begin
      cls     = CLS_ZERO;
      mant    = '0;
      eff_exp = '0;
`ifdef FP_DIV_PREP_DENORM_EN
      if (w_frac != 23'd0) begin
        cls     = CLS_SUB;
        mant    = {1'b0, w_frac};
        // Subnormals share the exponent of the smallest normal.
        eff_exp = {{(FP_EXP_W-1){1'b0}}, 1'b1};
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_div_operand_prep.sv
// ============================================================================
//  Module   : fp_div_operand_prep
//  Purpose  : Divider front-end. Captures a dividend/divisor pair, resolves
//             NaN/inf/zero cases to a final result, pre-normalises subnormal
//             mantissas one bit per cycle and issues sign, biased exponent
//             difference and two normalised mantissas to the divider core.
//  Ports    : clk    in  clock, rising edge
//             rst_n  in  asynchronous active-low reset
//             bus    fp_div_operand_prep_if.slave (operand + issue handshake)
//  Config   : FP_DIV_PREP_DENORM_EN - enables subnormal support and the NORM
//             state; undefined flushes subnormals to zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_div_operand_prep
  import fp_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  fp_div_operand_prep_if.slave  bus
);

  localparam logic signed [FP_EXP_W-1:0] c_bias = FP_EXP_W'(FP_BIAS);

  state_t                     r_state, w_state_nxt;
  logic [31:0]                r_n, r_x;
  logic [23:0]                r_mant_n, r_mant_x;
  logic signed [FP_EXP_W-1:0] r_exp_diff;
  logic                       r_sign, r_special;
  logic [31:0]                r_special_res;

  fp_class_t                  w_cls_n, w_cls_x;
  logic [23:0]                w_raw_mant_n, w_raw_mant_x;
  logic signed [FP_EXP_W-1:0] w_raw_exp_n, w_raw_exp_x, w_raw_exp_diff;
  logic                       w_sign, w_special;
  logic [31:0]                w_special_res;
  logic                       w_zero_n, w_zero_x, w_inf_n, w_inf_x, w_nan_n, w_nan_x;
  logic                       w_fin_n, w_fin_x;

  fp_classify u_cls_n (.op(r_n[30:0]), .cls(w_cls_n), .mant(w_raw_mant_n), .eff_exp(w_raw_exp_n));
  fp_classify u_cls_x (.op(r_x[30:0]), .cls(w_cls_x), .mant(w_raw_mant_x), .eff_exp(w_raw_exp_x));

  assign w_sign         = r_n[31] ^ r_x[31];
  assign w_zero_n       = (w_cls_n == CLS_ZERO);
  assign w_zero_x       = (w_cls_x == CLS_ZERO);
  assign w_inf_n        = (w_cls_n == CLS_INF);
  assign w_inf_x        = (w_cls_x == CLS_INF);
  assign w_nan_n        = (w_cls_n == CLS_NAN);
  assign w_nan_x        = (w_cls_x == CLS_NAN);
  assign w_fin_n        = !(w_inf_n || w_nan_n);
  assign w_fin_x        = !(w_inf_x || w_nan_x);
  assign w_raw_exp_diff = w_raw_exp_n - w_raw_exp_x + c_bias;

  // Special-case resolution; earlier rules take priority.
  always_comb begin
    w_special     = 1'b1;
    w_special_res = FP_QNAN;
    if (w_nan_n || w_nan_x || (w_zero_n && w_zero_x) || (w_inf_n && w_inf_x)) begin
      w_special_res = FP_QNAN;
    end else if ((w_inf_n && w_fin_x) || (!w_zero_n && w_zero_x)) begin
      w_special_res = {w_sign, 8'hFF, 23'h0};
    end else if ((w_zero_n && !w_zero_x) || (w_fin_n && w_inf_x)) begin
      w_special_res = {w_sign, 31'h0};
    end else begin
      w_special     = 1'b0;
      w_special_res = '0;
    end
  end

`ifdef FP_DIV_PREP_DENORM_EN
  localparam logic signed [FP_EXP_W-1:0] c_one = FP_EXP_W'(1);

  logic signed [FP_EXP_W-1:0] r_exp_n, r_exp_x, w_exp_n_sh, w_exp_x_sh;
  logic [23:0]                w_mant_n_sh, w_mant_x_sh;
  logic                       w_norm_done, w_sub_any;

  // Each operand shifts only while its hidden bit is still clear.
  assign w_mant_n_sh = r_mant_n[23] ? r_mant_n : {r_mant_n[22:0], 1'b0};
  assign w_mant_x_sh = r_mant_x[23] ? r_mant_x : {r_mant_x[22:0], 1'b0};
  assign w_exp_n_sh  = r_mant_n[23] ? r_exp_n  : r_exp_n - c_one;
  assign w_exp_x_sh  = r_mant_x[23] ? r_exp_x  : r_exp_x - c_one;
  assign w_norm_done = w_mant_n_sh[23] && w_mant_x_sh[23];
  assign w_sub_any   = (w_cls_n == CLS_SUB) || (w_cls_x == CLS_SUB);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (bus.in_valid) w_state_nxt = ST_CLASSIFY;
      ST_CLASSIFY: begin
        w_state_nxt = ST_ISSUE;
`ifdef FP_DIV_PREP_DENORM_EN
        if (!w_special && w_sub_any) w_state_nxt = ST_NORM;
      end
      ST_NORM: begin
        if (w_norm_done) w_state_nxt = ST_ISSUE;
`endif
      end
      ST_ISSUE:    if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture and issue-word datapath. Issue registers are only
  // written in CLASSIFY/NORM, so they stay stable throughout ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n           <= '0;
      r_x           <= '0;
      r_mant_n      <= '0;
      r_mant_x      <= '0;
      r_exp_diff    <= '0;
      r_sign        <= 1'b0;
      r_special     <= 1'b0;
      r_special_res <= '0;
`ifdef FP_DIV_PREP_DENORM_EN
      r_exp_n       <= '0;
      r_exp_x       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_n <= bus.n;
            r_x <= bus.x;
          end
        end
        ST_CLASSIFY: begin
          r_sign        <= w_sign;
          r_special     <= w_special;
          r_special_res <= w_special_res;
          r_mant_n      <= w_special ? '0 : w_raw_mant_n;
          r_mant_x      <= w_special ? '0 : w_raw_mant_x;
          r_exp_diff    <= w_special ? '0 : w_raw_exp_diff;
`ifdef FP_DIV_PREP_DENORM_EN
          r_exp_n       <= w_raw_exp_n;
          r_exp_x       <= w_raw_exp_x;
        end
        ST_NORM: begin
          r_mant_n      <= w_mant_n_sh;
          r_mant_x      <= w_mant_x_sh;
          r_exp_n       <= w_exp_n_sh;
          r_exp_x       <= w_exp_x_sh;
          r_exp_diff    <= w_exp_n_sh - w_exp_x_sh + c_bias;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == ST_IDLE);
  assign bus.out_valid   = (r_state == ST_ISSUE);
  assign bus.sign        = r_sign;
  assign bus.exp_diff    = r_exp_diff;
  assign bus.mant_n      = r_mant_n;
  assign bus.mant_x      = r_mant_x;
  assign bus.special     = r_special;
  assign bus.special_res = r_special_res;

endmodule

`default_nettype wire
